// File: rtl/ipv4_decode_if.sv
// Byte-stream input and decoded-header/payload outputs of the IPv4 receive parser.
interface ipv4_decode_if;
  logic        valid;
  logic [7:0]  din;
  logic [31:0] src_ip;
  logic [31:0] dst_ip;
  logic [7:0]  protocol;
  logic [15:0] payload_len;
  logic        hdr_done;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        done;
  logic        err;
  logic        busy;

  modport master (
    output valid, din,
    input  src_ip, dst_ip, protocol, payload_len, hdr_done,
    input  dout, dout_valid, done, err, busy
  );

  modport slave (
    input  valid, din,
    output src_ip, dst_ip, protocol, payload_len, hdr_done,
    output dout, dout_valid, done, err, busy
  );
endinterface

// File: rtl/ipv4_decode.sv
// IPv4 header parser: validates the header, latches fields, streams the payload.
// Optional header checksum verification is enabled by defining IPV4_CHECKSUM_EN.
module ipv4_decode #(
  parameter logic [31:0] IP_ADDR      = 32'h69696969,
  parameter bit          ACCEPT_BCAST = 1'b1
) (
  input logic          clk,
  input logic          rst,
  ipv4_decode_if.slave bus
);
  typedef enum logic [2:0] {IDLE, HDR, OPT, PAYLOAD, DRAIN, DROP} state_t;

  state_t      state_reg;
  logic [5:0]  cnt_reg;
  logic [3:0]  ihl_reg;
  logic [15:0] total_len_reg;
  logic [13:0] frag_reg;       // MF flag and fragment offset; DF and reserved bit are irrelevant
  logic [7:0]  proto_reg;
  logic [31:0] src_reg;
  logic [31:0] dst_reg;
  logic [15:0] remain_reg;

  logic [31:0] src_ip_reg;
  logic [31:0] dst_ip_reg;
  logic [7:0]  protocol_reg;
  logic [15:0] payload_len_reg;
  logic        hdr_done_reg;
  logic [7:0]  dout_reg;
  logic        dout_valid_reg;
  logic        done_reg;
  logic        err_reg;
  logic        busy_reg;

  logic [5:0]  hdr_len;
  logic [31:0] dst_final;
  logic [15:0] pay_len;
  logic        last_hdr;
  logic        hdr_ok;
  logic        cks_ok;

  assign hdr_len = {ihl_reg, 2'b00};

  always_comb begin
    // At byte 19 the low dst byte is still on din; later it is fully registered.
    dst_final = (state_reg == HDR) ? {dst_reg[23:0], bus.din} : dst_reg;
    pay_len   = total_len_reg - {10'd0, hdr_len};
    last_hdr  = bus.valid &&
                (((state_reg == HDR) && (cnt_reg == 6'd19) && (ihl_reg <= 4'd5)) ||
                 ((state_reg == OPT) && (cnt_reg == hdr_len - 6'd1)));
    hdr_ok    = (ihl_reg >= 4'd5) &&
                (total_len_reg >= {10'd0, hdr_len}) &&
                (frag_reg == 14'd0) &&
                ((dst_final == IP_ADDR) || (ACCEPT_BCAST && (dst_final == 32'hFFFF_FFFF))) &&
                cks_ok;
  end

`ifdef IPV4_CHECKSUM_EN
  logic [7:0]  cks_hi_reg;
  logic [15:0] cks_acc_reg;
  logic [15:0] cks_word_sum;

  function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  assign cks_word_sum = ones_add(cks_acc_reg, {cks_hi_reg, bus.din});
  assign cks_ok       = (cks_word_sum == 16'hFFFF);

  // Even header bytes are the high half of a word, odd bytes complete it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cks_hi_reg  <= 8'd0;
      cks_acc_reg <= 16'd0;
    end else if (state_reg == IDLE) begin
      if (bus.valid) begin
        cks_hi_reg  <= bus.din;
        cks_acc_reg <= 16'd0;
      end
    end else if (((state_reg == HDR) || (state_reg == OPT)) && bus.valid) begin
      if (!cnt_reg[0]) cks_hi_reg  <= bus.din;
      else             cks_acc_reg <= cks_word_sum;
    end
  end
`else
  assign cks_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= 6'd0;
      ihl_reg         <= 4'd0;
      total_len_reg   <= 16'd0;
      frag_reg        <= 14'd0;
      proto_reg       <= 8'd0;
      src_reg         <= 32'd0;
      dst_reg         <= 32'd0;
      remain_reg      <= 16'd0;
      src_ip_reg      <= 32'd0;
      dst_ip_reg      <= 32'd0;
      protocol_reg    <= 8'd0;
      payload_len_reg <= 16'd0;
      hdr_done_reg    <= 1'b0;
      dout_reg        <= 8'd0;
      dout_valid_reg  <= 1'b0;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      hdr_done_reg   <= 1'b0;
      dout_valid_reg <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (bus.valid) begin
            cnt_reg         <= 6'd1;
            ihl_reg         <= bus.din[3:0];
            busy_reg        <= 1'b1;
            src_ip_reg      <= 32'd0;
            dst_ip_reg      <= 32'd0;
            protocol_reg    <= 8'd0;
            payload_len_reg <= 16'd0;
            if (bus.din[7:4] != 4'd4) begin
              err_reg   <= 1'b1;
              state_reg <= DROP;
            end else begin
              state_reg <= HDR;
            end
          end
        end
        HDR: begin
          if (!bus.valid) begin
            err_reg   <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 6'd1;
            case (cnt_reg)
              6'd2:  total_len_reg[15:8] <= bus.din;
              6'd3:  total_len_reg[7:0]  <= bus.din;
              6'd6:  frag_reg[13:8]      <= bus.din[5:0];
              6'd7:  frag_reg[7:0]       <= bus.din;
              6'd9:  proto_reg           <= bus.din;
              6'd12, 6'd13, 6'd14, 6'd15: src_reg <= {src_reg[23:0], bus.din};
              6'd16, 6'd17, 6'd18, 6'd19: dst_reg <= {dst_reg[23:0], bus.din};
              default: ;
            endcase
            if ((cnt_reg == 6'd19) && (ihl_reg > 4'd5)) state_reg <= OPT;
          end
        end
        OPT: begin
          if (!bus.valid) begin
            err_reg   <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 6'd1;
          end
        end
        PAYLOAD: begin
          if (!bus.valid) begin
            err_reg   <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            dout_reg       <= bus.din;
            dout_valid_reg <= 1'b1;
            remain_reg     <= remain_reg - 16'd1;
            if (remain_reg == 16'd1) begin
              done_reg  <= 1'b1;
              state_reg <= DRAIN;
            end
          end
        end
        DRAIN, DROP: begin
          if (!bus.valid) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase

      // Final header byte: all checks resolve together, overriding the per-state update.
      if (last_hdr) begin
        if (hdr_ok) begin
          hdr_done_reg    <= 1'b1;
          src_ip_reg      <= src_reg;
          dst_ip_reg      <= dst_final;
          protocol_reg    <= proto_reg;
          payload_len_reg <= pay_len;
          remain_reg      <= pay_len;
          if (pay_len == 16'd0) begin
            done_reg  <= 1'b1;
            state_reg <= DRAIN;
          end else begin
            state_reg <= PAYLOAD;
          end
        end else begin
          err_reg   <= 1'b1;
          state_reg <= DROP;
        end
      end
    end
  end

  assign bus.src_ip      = src_ip_reg;
  assign bus.dst_ip      = dst_ip_reg;
  assign bus.protocol    = protocol_reg;
  assign bus.payload_len = payload_len_reg;
  assign bus.hdr_done    = hdr_done_reg;
  assign bus.dout        = dout_reg;
  assign bus.dout_valid  = dout_valid_reg;
  assign bus.done        = done_reg;
  assign bus.err         = err_reg;
  assign bus.busy        = busy_reg;
endmodule

// File: tb/tb_ipv4_decode.sv
// Randomized and directed frames checked against a frame-level IPv4 acceptance model.
module tb_ipv4_decode;
  localparam logic [31:0] LOCAL_IP = 32'h69696969;
`ifdef IPV4_CHECKSUM_EN
  localparam bit CKS_ON = 1'b1;
`else
  localparam bit CKS_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ipv4_decode_if bus();

  ipv4_decode #(.IP_ADDR(LOCAL_IP), .ACCEPT_BCAST(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors   = 0;
  int checks   = 0;
  int frame_no = 0;
  logic [7:0] frm[$];
  logic [7:0] good_hdr[20];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s frame=%0d got=%h exp=%h", tag, frame_no, got, exp);
    end
  endtask

  function automatic int hdr_bytes();
    int ihl;
    ihl = int'(frm[0][3:0]);
    return (ihl < 5) ? 20 : 4 * ihl;
  endfunction

  // One's-complement sum of the first hl bytes, fully folded at the end.
  function automatic int ones_sum(input int hl);
    int s;
    s = 0;
    for (int k = 0; k < hl; k += 2) s += int'({frm[k], frm[k+1]});
    while (s > 32'h0000_FFFF) s = (s & 32'h0000_FFFF) + (s >> 16);
    return s;
  endfunction

  task automatic fix_cks();
    int s;
    frm[10] = 8'h00;
    frm[11] = 8'h00;
    s = ~ones_sum(hdr_bytes()) & 32'h0000_FFFF;
    frm[10] = 8'(s >> 8);
    frm[11] = 8'(s);
  endtask

  task automatic build_frame(input int ihl, input int plen, input int pad,
                             input logic [31:0] dst, input logic [7:0] proto);
    int hl;
    logic [15:0] tl;
    logic [31:0] src;
    hl  = (ihl < 5) ? 20 : 4 * ihl;
    tl  = 16'(4 * ihl + plen);
    src = $urandom;
    frm.delete();
    frm.push_back({4'h4, 4'(ihl)});
    frm.push_back(8'($urandom));
    frm.push_back(tl[15:8]);
    frm.push_back(tl[7:0]);
    frm.push_back(8'($urandom));
    frm.push_back(8'($urandom));
    frm.push_back(($urandom_range(0, 1) != 0) ? 8'h40 : 8'h00);
    frm.push_back(8'h00);
    frm.push_back(8'($urandom_range(1, 255)));
    frm.push_back(proto);
    frm.push_back(8'h00);
    frm.push_back(8'h00);
    for (int k = 0; k < 4; k++) frm.push_back(src[31-8*k -: 8]);
    for (int k = 0; k < 4; k++) frm.push_back(dst[31-8*k -: 8]);
    for (int k = 20; k < hl; k++) frm.push_back(8'($urandom));
    for (int k = 0; k < plen + pad; k++) frm.push_back(8'($urandom));
    fix_cks();
  endtask

  task automatic load_good();
    frm.delete();
    for (int k = 0; k < 20; k++) frm.push_back(good_hdr[k]);
    for (int k = 0; k < 10; k++) frm.push_back(8'(k));
  endtask

  // Drives n_send bytes of frm, then valid=0; checks every output cycle against the model.
  task automatic run_frame(input string name, input int n_send);
    int ver, ihl, hlen, hdr_last, tl, plen;
    bit ok, complete, e_err, e_hdr, e_dv, e_done;
    logic [31:0] srcv, dstv;
    ver      = int'(frm[0][7:4]);
    ihl      = int'(frm[0][3:0]);
    hlen     = 4 * ihl;
    hdr_last = (ihl <= 5) ? 19 : hlen - 1;
    tl       = int'({frm[2], frm[3]});
    srcv     = {frm[12], frm[13], frm[14], frm[15]};
    dstv     = {frm[16], frm[17], frm[18], frm[19]};
    ok = (ver == 4) && (ihl >= 5) && (tl >= hlen) && ((frm[6] & 8'h3F) == 8'h00) &&
         (frm[7] == 8'h00) && ((dstv == LOCAL_IP) || (dstv == 32'hFFFF_FFFF)) &&
         (!CKS_ON || (ones_sum(hdr_last + 1) == 32'h0000_FFFF));
    plen = ok ? tl - hlen : 0;
    if (ver != 4) complete = 1'b1;
    else complete = (n_send > hdr_last) && (!ok || (n_send > hdr_last + plen));
    frame_no++;

    for (int i = 0; i <= n_send; i++) begin
      @(negedge clk);
      if (i > 0) begin
        int b;
        b      = i - 1;
        e_err  = (ver != 4) ? (b == 0) : (!ok && (b == hdr_last));
        e_hdr  = ok && (b == hdr_last);
        e_dv   = ok && (b > hdr_last) && (b <= hdr_last + plen);
        e_done = ok && ((plen == 0) ? (b == hdr_last) : (b == hdr_last + plen));
        check_eq("err", bus.err, e_err);
        check_eq("hdr_done", bus.hdr_done, e_hdr);
        check_eq("dout_valid", bus.dout_valid, e_dv);
        check_eq("done", bus.done, e_done);
        check_eq("busy", bus.busy, 1);
        if (e_dv) check_eq("dout", bus.dout, frm[b]);
        if (e_hdr) begin
          check_eq("src_ip", bus.src_ip, srcv);
          check_eq("dst_ip", bus.dst_ip, dstv);
          check_eq("protocol", bus.protocol, frm[9]);
          check_eq("payload_len", bus.payload_len, plen);
        end
      end
      if (i < n_send) begin
        bus.valid = 1'b1;
        bus.din   = frm[i];
      end else begin
        bus.valid = 1'b0;
        bus.din   = 8'h00;
      end
    end
    @(negedge clk);
    check_eq("end_err", bus.err, !complete);
    check_eq("end_busy", bus.busy, 0);
    check_eq("end_done", bus.done, 0);
    check_eq("end_dout_valid", bus.dout_valid, 0);
    check_eq("end_hdr_done", bus.hdr_done, 0);
    @(negedge clk);
    check_eq("idle_err", bus.err, 0);
    $display("frame %0d %s: ihl=%0d bytes=%0d sent=%0d accept=%0d plen=%0d complete=%0d",
             frame_no, name, ihl, frm.size(), n_send, ok, plen, complete);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, bus.busy, 0);
    check_eq({tag, "_dout_valid"}, bus.dout_valid, 0);
    check_eq({tag, "_dout"}, bus.dout, 0);
    check_eq({tag, "_hdr_done"}, bus.hdr_done, 0);
    check_eq({tag, "_done"}, bus.done, 0);
    check_eq({tag, "_err"}, bus.err, 0);
    check_eq({tag, "_src_ip"}, bus.src_ip, 0);
    check_eq({tag, "_dst_ip"}, bus.dst_ip, 0);
    check_eq({tag, "_protocol"}, bus.protocol, 0);
    check_eq({tag, "_payload_len"}, bus.payload_len, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    good_hdr = '{8'h45, 8'h00, 8'h00, 8'h1E, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                 8'hA7, 8'h53, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'h69, 8'h69, 8'h69, 8'h69};
    rst       = 1'b1;
    bus.valid = 1'b0;
    bus.din   = 8'h00;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    load_good();
    run_frame("good_udp", frm.size());
    load_good();
    frm[11] = 8'h54;
    run_frame("bad_cks", frm.size());
    build_frame(5, 10, 4, 32'hC0A8_0002, 8'h11);
    run_frame("wrong_dst", frm.size());
    build_frame(5, 10, 4, 32'hFFFF_FFFF, 8'h11);
    run_frame("bcast", frm.size());
    build_frame(6, 10, 0, LOCAL_IP, 8'h11);
    run_frame("ihl6", frm.size());
    build_frame(5, 8, 18, LOCAL_IP, 8'h01);
    run_frame("padding", frm.size());
    build_frame(5, 0, 6, LOCAL_IP, 8'h11);
    run_frame("zero_len", frm.size());
    load_good();
    run_frame("truncated", 25);
    load_good();
    run_frame("good_after", frm.size());

    // Asynchronous reset in the middle of the payload.
    load_good();
    frame_no++;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      bus.valid = 1'b1;
      bus.din   = frm[i];
    end
    @(posedge clk);
    #2;
    check_eq("pre_rst_dout_valid", bus.dout_valid, 1);
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    bus.valid = 1'b0;
    bus.din   = 8'h00;
    rst       = 1'b0;
    @(negedge clk);
    $display("frame %0d reset_mid_payload: reset asserted after 25 bytes", frame_no);
    load_good();
    run_frame("after_rst", frm.size());

    for (int f = 0; f < 150; f++) begin
      int ihl, plen, pad, kind, n, v;
      logic [31:0] dst;
      ihl  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : $urandom_range(5, 8);
      plen = $urandom_range(0, 24);
      pad  = $urandom_range(0, 12);
      case ($urandom_range(0, 3))
        0, 1:    dst = LOCAL_IP;
        2:       dst = 32'hFFFF_FFFF;
        default: dst = $urandom;
      endcase
      build_frame(ihl, plen, pad, dst, 8'($urandom));
      kind = $urandom_range(0, 11);
      case (kind)
        0: begin
          v = $urandom_range(0, 15);
          if (v == 4) v = 6;
          frm[0] = {4'(v), frm[0][3:0]};
          fix_cks();
        end
        1: begin frm[6] = frm[6] | 8'h20; fix_cks(); end
        2: begin frm[7] = 8'($urandom_range(1, 255)); fix_cks(); end
        3: begin
          if (ihl >= 5) begin
            frm[2] = 8'h00;
            frm[3] = 8'(4 * ihl - 1);
            fix_cks();
          end
        end
        4: frm[11] = frm[11] ^ 8'($urandom_range(1, 255));
        default: ;
      endcase
      n = frm.size();
      if ($urandom_range(0, 5) == 0) n = $urandom_range(1, frm.size() - 1);
      run_frame("random", n);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
